// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns the 128-bit state and round counter around one shared round datapath.
// Optional abort input is enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int NR     = 14,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef AES_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [RIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk_in,
  output logic [127:0]      rnd_in,
  output logic              rnd_last,
  input  logic [127:0]      rnd_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(NR);
  localparam logic [RIDX_W-1:0] ONE_RND  = RIDX_W'(1);

  fsm_e              fsm_q, fsm_d;
  logic [RIDX_W-1:0] round_q, round_d;
  logic [127:0]      blk_q, blk_d;
  logic              abort_req;

`ifdef AES_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      blk_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      blk_q   <= blk_d;
    end
  end

  // The final ROUND cycle hands over to DONE; >= keeps a corrupted counter from running past NR.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    blk_d   = blk_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = in_data ^ rk_in;
          round_d = ONE_RND;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (abort_req) begin
          blk_d   = '0;
          round_d = '0;
          fsm_d   = IDLE;
        end else begin
          blk_d = rnd_out ^ rk_in;
          if (round_q >= LAST_RND) begin
            round_d = '0;
            fsm_d   = DONE;
          end else begin
            round_d = round_q + ONE_RND;
          end
        end
      end
      DONE: begin
        if (abort_req) begin
          blk_d   = '0;
          round_d = '0;
          fsm_d   = IDLE;
        end else if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        blk_d   = '0;
        round_d = '0;
        fsm_d   = IDLE;
      end
    endcase
  end

  // Datapath-facing outputs depend only on registers, never on inputs.
  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == ROUND);
  assign out_valid = (fsm_q == DONE);
  assign rk_idx    = (fsm_q == ROUND) ? round_q : '0;
  assign rnd_last  = (fsm_q == ROUND) && (round_q == LAST_RND);
  assign rnd_in    = blk_q;
  assign out_data  = blk_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies an AES round datapath and AES-256 key store, and checks against a whole-cipher model.
// Abort checks are compiled in when AES_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;

  localparam int NR     = 14;
  localparam int RIDX_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [127:0]      in_data = '0;
  logic [RIDX_W-1:0] rk_idx;
  logic [127:0]      rk_in = '0;
  logic [127:0]      rnd_in;
  logic              rnd_last;
  logic [127:0]      rnd_out = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [127:0]      out_data;
  logic              busy;
`ifdef AES_CTRL_ABORT_EN
  logic              abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rks  [NR+1];
  logic         tbReady = 1'b0;

  aes_round_ctrl #(.NR(NR), .RIDX_W(RIDX_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .rk_idx(rk_idx),
    .rk_in(rk_in),
    .rnd_in(rnd_in),
    .rnd_last(rnd_last),
    .rnd_out(rnd_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // One SubBytes/ShiftRows/(MixColumns) pass, bytes in column-major order with byte 0 in bits 127:120.
  function automatic logic [127:0] roundFn(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  function automatic logic [127:0] aesEnc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rks[0];
    for (int r = 1; r <= NR; r++) s = roundFn(s, r == NR) ^ rks[r];
    return s;
  endfunction

  task automatic buildTables(input logic [255:0] key);
    logic [7:0]  inv;
    logic [31:0] w [4*(NR+1)];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 4*(NR+1); i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subWord({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (i % 8 == 4) begin
        tmp = subWord(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Environment around the DUT: key store and round datapath respond in the same cycle.
  always @(rk_idx or tbReady) rk_in = (int'(rk_idx) <= NR) ? rks[rk_idx] : '0;
  always @(rnd_in or rnd_last or tbReady) rnd_out = tbReady ? roundFn(rnd_in, rnd_last) : '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents a block and returns at the falling edge right after the accepting edge.
  task automatic applyStimulus(input logic [127:0] pt, input logic ordy);
    int w = 0;
    in_valid  = 1'b1;
    in_data   = pt;
    out_ready = ordy;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept in_ready", 128'(in_ready), 128'(1));
    chk("idle rk_idx", 128'(rk_idx), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rnd128();
  endtask

  // Walks the rounds, then checks the held ciphertext while out_ready stays low for hold cycles.
  task automatic checkOutput(input logic [127:0] exp, input int hold, input string tag);
    int j = 0;
    while (!out_valid && j < 3*NR) begin
      chk({tag, " rk_idx"}, 128'(rk_idx), 128'(j+1));
      chk({tag, " rnd_last"}, 128'(rnd_last), 128'(j+1 == NR));
      chk({tag, " busy"}, 128'(busy), 128'(1));
      chk({tag, " in_ready round"}, 128'(in_ready), 128'(0));
      @(negedge clk);
      j++;
    end
    chk({tag, " latency"}, 128'(j), 128'(NR));
    chk({tag, " out_valid"}, 128'(out_valid), 128'(1));
    chk({tag, " out_data"}, out_data, exp);
    chk({tag, " busy done"}, 128'(busy), 128'(0));
    in_valid = 1'b1;
    in_data  = rnd128();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 128'(out_valid), 128'(1));
      chk({tag, " hold data"}, out_data, exp);
      chk({tag, " hold in_ready"}, 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " release valid"}, 128'(out_valid), 128'(0));
    chk({tag, " release in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, " data kept"}, out_data, exp);
    out_ready = 1'b0;
  endtask

  task automatic runBlock(input logic [127:0] pt, input int hold, input string tag);
    applyStimulus(pt, hold == 0);
    checkOutput(aesEnc(pt), hold, tag);
  endtask

  initial begin
    logic [127:0] pts  [3];
    logic [127:0] exps [3];
    logic [127:0] pt;
    int nacc, nout, lastAcc, w;
    logic acc;

    buildTables(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    tbReady = 1'b1;
    $display("[TB] tables built, starting");

    repeat (3) @(negedge clk);
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_data", out_data, 128'(0));
    chk("reset rk_idx", 128'(rk_idx), 128'(0));
    chk("reset rnd_last", 128'(rnd_last), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] FIPS-197 C.3 vector with backpressure");
    applyStimulus(128'h00112233445566778899aabbccddeeff, 1'b0);
    checkOutput(128'h8ea2b7ca516745bfeafc49904b496089, 20, "fips");

    $display("[TB] random blocks");
    for (int i = 0; i < 4; i++) runBlock(rnd128(), int'($urandom_range(0, 3)), "rand");

    $display("[TB] back-to-back");
    for (int i = 0; i < 3; i++) begin
      pts[i]  = rnd128();
      exps[i] = aesEnc(pts[i]);
    end
    in_data = pts[0]; in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nout = 0; lastAcc = 0;
    for (int c = 0; c < 120 && nout < 3; c++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        chk("b2b out_data", out_data, exps[nout]);
        nout++;
      end
      if (acc) begin
        if (nacc > 0) chk("b2b spacing", 128'(c - lastAcc), 128'(NR + 2));
        lastAcc = c;
        nacc++;
      end
      @(negedge clk);
      if (acc) begin
        if (nacc < 3) in_data = pts[nacc];
        else in_valid = 1'b0;
      end
    end
    chk("b2b outputs", 128'(nout), 128'(3));
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    $display("[TB] reset at round 7");
    applyStimulus(rnd128(), 1'b0);
    w = 0;
    while (rk_idx != 4'd7 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("mid rk_idx", 128'(rk_idx), 128'(7));
    rst_n = 1'b0;
    #1;
    chk("mid-reset out_valid", 128'(out_valid), 128'(0));
    chk("mid-reset in_ready", 128'(in_ready), 128'(1));
    chk("mid-reset rk_idx", 128'(rk_idx), 128'(0));
    chk("mid-reset busy", 128'(busy), 128'(0));
    chk("mid-reset out_data", out_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("discarded no out_valid", 128'(out_valid), 128'(0));
    end
    runBlock(rnd128(), 1, "after-reset");

`ifdef AES_CTRL_ABORT_EN
    $display("[TB] abort in ROUND");
    applyStimulus(rnd128(), 1'b0);
    w = 0;
    while (rk_idx != 4'd5 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("abort rk_idx", 128'(rk_idx), 128'(5));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort in_ready", 128'(in_ready), 128'(1));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort rk_idx idle", 128'(rk_idx), 128'(0));
    chk("abort out_data", out_data, 128'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort no out_valid", 128'(out_valid), 128'(0));
    end

    $display("[TB] abort in DONE against out_ready");
    applyStimulus(rnd128(), 1'b0);
    w = 0;
    while (!out_valid && w < 3*NR) begin
      @(negedge clk);
      w++;
    end
    chk("abort-done out_valid", 128'(out_valid), 128'(1));
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk("abort-done valid", 128'(out_valid), 128'(0));
    chk("abort-done out_data", out_data, 128'(0));
    chk("abort-done in_ready", 128'(in_ready), 128'(1));

    $display("[TB] abort in IDLE is ignored");
    pt = rnd128();
    abort = 1'b1;
    applyStimulus(pt, 1'b1);
    abort = 1'b0;
    chk("idle abort busy", 128'(busy), 128'(1));
    checkOutput(aesEnc(pt), 0, "idle-abort");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
